// File: rtl/gobou_serial_out.sv
// Parallel-to-serial result stage: captures CORE saturated lanes on a load pulse
// and streams them out one word per cycle, lane 0 first.

module gobou_serial_sat #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 24
) (
  input  logic [AWIDTH-1:0] in_i,
  input  logic              relu_i,
  output logic [DWIDTH-1:0] out_o
);
  localparam logic signed [AWIDTH-1:0] MAXV = {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AWIDTH-1:0] MINV = {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  logic signed [AWIDTH-1:0] v;

  always_comb begin
    v = (relu_i && in_i[AWIDTH-1]) ? '0 : in_i;
    if (v > MAXV)      out_o = MAXV[DWIDTH-1:0];
    else if (v < MINV) out_o = MINV[DWIDTH-1:0];
    else               out_o = v[DWIDTH-1:0];
  end
endmodule

module gobou_serial_out #(
  parameter int CORE   = 16,
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 24
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     serial_we,
  input  logic                     relu_en,
  input  logic [CORE*AWIDTH-1:0]   in_data,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  output logic [$clog2(CORE)-1:0]  out_index,
  output logic                     busy
);
  localparam int IW = $clog2(CORE);
  localparam logic [IW-1:0] LAST = IW'(CORE-1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [CORE-1:0][DWIDTH-1:0]   sreg_q, sreg_d;
  logic [CORE-1:0][DWIDTH-1:0]   cap;

  for (genvar g = 0; g < CORE; g++) begin : g_lane
    gobou_serial_sat #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_sat (
      .in_i   (in_data[g*AWIDTH +: AWIDTH]),
      .relu_i (relu_en),
      .out_o  (cap[g])
    );
  end

  // A load always restarts, even on the last word of a previous stream.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    if (serial_we) begin
      state_d = SHIFT;
      idx_d   = '0;
      sreg_d  = cap;
    end else if (state_q == SHIFT) begin
      if (idx_q == LAST) begin
        state_d = IDLE;
        idx_d   = '0;
        sreg_d  = '0;
      end else begin
        idx_d  = idx_q + IW'(1);
        sreg_d = {{DWIDTH{1'b0}}, sreg_q[CORE-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
    end
  end

  assign out_valid = (state_q == SHIFT);
  assign busy      = out_valid;
  assign out_index = idx_q;
  assign out_data  = sreg_q[0];
endmodule

// File: tb/tb_gobou_serial_out.sv
// Directed bench for gobou_serial_out: load-time arithmetic model checked every
// cycle, plus literal expectations on the captured output stream.

module tb_gobou_serial_out;
  localparam int CORE = 16, DWIDTH = 16, AWIDTH = 24;
  localparam int IW = $clog2(CORE);

  logic clk = 0, xrst = 0, serial_we = 0, relu_en = 0;
  logic [CORE*AWIDTH-1:0] in_data = '0;
  logic [DWIDTH-1:0] out_data;
  logic out_valid, busy;
  logic [IW-1:0] out_index;

  gobou_serial_out #(.CORE(CORE), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .xrst(xrst), .serial_we(serial_we), .relu_en(relu_en),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .out_index(out_index), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  int lanes [CORE];
  longint log_data[$];
  int     log_cyc[$];

  // model state
  bit     loaded = 0;
  int     load_cyc = 0;
  longint exp_w [CORE];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint conv(input longint x, input bit relu);
    longint v, hi, lo;
    hi = (longint'(1) <<< (DWIDTH-1)) - 1;
    lo = -(longint'(1) <<< (DWIDTH-1));
    v = (relu && x < 0) ? 0 : x;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v;
  endfunction

  always @(posedge clk) begin
    int k;
    bit ev;
    cyc++;
    if (!xrst) loaded = 0;
    else if (serial_we) begin
      loaded = 1;
      load_cyc = cyc;
      for (int i = 0; i < CORE; i++)
        exp_w[i] = conv(longint'($signed(in_data[i*AWIDTH +: AWIDTH])), relu_en);
    end
    #1;
    k  = cyc - load_cyc;
    ev = loaded && k < CORE;
    chk("out_valid", out_valid, ev);
    chk("busy", busy, ev);
    chk("out_data", longint'($signed(out_data)), ev ? exp_w[k] : 0);
    chk("out_index", out_index, ev ? k : 0);
    if (out_valid) begin
      log_data.push_back(longint'($signed(out_data)));
      log_cyc.push_back(cyc);
    end
  end

  task automatic load(input bit relu);
    for (int i = 0; i < CORE; i++) in_data[i*AWIDTH +: AWIDTH] = AWIDTH'(lanes[i]);
    relu_en = relu;
    serial_we = 1;
    @(negedge clk);
    serial_we = 0;
    relu_en = $urandom_range(0, 1);
    in_data = {CORE{24'h5A5A5A}};
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    serial_we = 1;  // ignored under reset
    idle(2);
    serial_we = 0;
    xrst = 1;
    idle(2);
    chk("reset_empty_log", log_data.size(), 0);

    // 1: ramp i*3-20
    log_data.delete(); log_cyc.delete();
    for (int i = 0; i < CORE; i++) lanes[i] = i*3 - 20;
    load(0);
    idle(20);
    chk("t1_count", log_data.size(), 16);
    chk("t1_first", log_data[0], -20);
    chk("t1_second", log_data[1], -17);
    chk("t1_last", log_data[15], 25);

    // 2: saturation
    log_data.delete(); log_cyc.delete();
    for (int i = 0; i < CORE; i++) lanes[i] = (i % 2) ? -100000 : 100000;
    lanes[0] = 40000; lanes[1] = -40000; lanes[2] = 32767; lanes[3] = -32768;
    lanes[4] = 1234;
    load(0);
    idle(20);
    chk("t2_l0", log_data[0], 32767);
    chk("t2_l1", log_data[1], -32768);
    chk("t2_l2", log_data[2], 32767);
    chk("t2_l3", log_data[3], -32768);
    chk("t2_l4", log_data[4], 1234);

    // 3: relu on/off
    for (int i = 0; i < CORE; i++) lanes[i] = 0;
    lanes[0] = -5; lanes[1] = 7; lanes[2] = -1; lanes[3] = 0;
    log_data.delete(); log_cyc.delete();
    load(1);
    idle(20);
    chk("t3r_l0", log_data[0], 0);
    chk("t3r_l1", log_data[1], 7);
    chk("t3r_l2", log_data[2], 0);
    chk("t3r_l3", log_data[3], 0);
    log_data.delete(); log_cyc.delete();
    load(0);
    idle(20);
    chk("t3n_l0", log_data[0], -5);
    chk("t3n_l1", log_data[1], 7);
    chk("t3n_l2", log_data[2], -1);

    // 4: back-to-back, 16 apart -> gapless 32 words
    log_data.delete(); log_cyc.delete();
    for (int i = 0; i < CORE; i++) lanes[i] = 100 + i;
    load(0);
    idle(15);
    for (int i = 0; i < CORE; i++) lanes[i] = 200 + i;
    load(0);
    idle(20);
    chk("t4_count", log_data.size(), 32);
    chk("t4_span", log_cyc[31] - log_cyc[0], 31);
    chk("t4_a15", log_data[15], 115);
    chk("t4_b0", log_data[16], 200);
    chk("t4_b15", log_data[31], 215);

    // 5: restart 5 cycles in
    log_data.delete(); log_cyc.delete();
    for (int i = 0; i < CORE; i++) lanes[i] = 300 + i;
    load(0);
    idle(4);
    for (int i = 0; i < CORE; i++) lanes[i] = 400 + i;
    load(0);
    idle(20);
    chk("t5_count", log_data.size(), 21);
    chk("t5_a4", log_data[4], 304);
    chk("t5_b0", log_data[5], 400);
    chk("t5_b15", log_data[20], 415);

    // 6: reset mid-shift, load attempted during reset
    log_data.delete(); log_cyc.delete();
    for (int i = 0; i < CORE; i++) lanes[i] = 500 + i;
    load(0);
    idle(7);
    xrst = 0;
    idle(1);
    serial_we = 1;
    idle(2);
    serial_we = 0;
    xrst = 1;
    idle(20);
    chk("t6_count", log_data.size(), 8);
    chk("t6_last", log_data[7], 507);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
